// File: rtl/shift_sequencer.sv
// Multi-step shift/rotate sequencer: latches an operand, mode and step count, then applies the operation once per clock.
// Optional serial fill input enabled with SHIFT_SEQ_SERIAL_IN_EN; default build fills with 0.
//
// state   | meaning
// ST_IDLE | waiting for start; dout holds last result
// ST_RUN  | one operation step per clock, busy high
// ST_DONE | one-cycle done pulse, then back to IDLE

module shift_sequencer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [CNT_W-1:0] count,
   input  logic [WIDTH-1:0] din,
   input  logic             abort,
`ifdef SHIFT_SEQ_SERIAL_IN_EN
   input  logic             sin,
`endif
   output logic [WIDTH-1:0] dout,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_dout, w_dout_nxt, w_step;
   logic [1:0]       r_mode, w_mode_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_busy, r_done;
   logic             w_fill;

`ifdef SHIFT_SEQ_SERIAL_IN_EN
   assign w_fill = sin;
`else
   assign w_fill = 1'b0;
`endif

   always_comb begin
      w_step = r_dout;
      case (r_mode)
         2'b01:   w_step = {r_dout[WIDTH-2:0], w_fill};
         2'b10:   w_step = {w_fill, r_dout[WIDTH-1:1]};
         2'b11:   w_step = {r_dout[0], r_dout[WIDTH-1:1]};
         default: w_step = r_dout;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_dout_nxt  = r_dout;
      w_mode_nxt  = r_mode;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_dout_nxt  = din;
               w_mode_nxt  = mode;
               w_cnt_nxt   = count;
               w_state_nxt = (count != '0) ? ST_RUN : ST_DONE;
            end
         end
         ST_RUN: begin
            // abort freezes the partial result and beats a coincident last step
            if (abort) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_dout_nxt = w_step;
               if (r_cnt != '0) w_cnt_nxt = r_cnt - CNT_W'(1);
               if (r_cnt <= CNT_W'(1)) w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_dout  <= '0;
         r_mode  <= 2'b00;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_dout  <= w_dout_nxt;
         r_mode  <= w_mode_nxt;
         r_cnt   <= w_cnt_nxt;
         r_busy  <= (w_state_nxt == ST_RUN);
         r_done  <= (w_state_nxt == ST_DONE);
      end
   end

   assign dout = r_dout;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer; serial-fill vectors run only when SHIFT_SEQ_SERIAL_IN_EN is defined.

module tb_shift_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [1:0] mode;
   logic [3:0] count;
   logic [3:0] din;
   logic       abort;
   logic       sin;
   logic [3:0] dout;
   logic       busy;
   logic       done;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   shift_sequencer #(.WIDTH(4), .CNT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .mode  (mode),
      .count (count),
      .din   (din),
      .abort (abort),
`ifdef SHIFT_SEQ_SERIAL_IN_EN
      .sin   (sin),
`endif
      .dout  (dout),
      .busy  (busy),
      .done  (done)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic [3:0] d, input logic [1:0] m, input logic [3:0] c);
      din   = d;
      mode  = m;
      count = c;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // run until done, counting edges after load and cycles seen busy
   task automatic wait_done(output int cyc, output int nb);
      cyc = 0;
      nb  = 0;
      while (!done && cyc < 20) begin
         if (busy) nb++;
         tick();
         cyc++;
      end
   endtask

   int cyc, nb;

   initial begin
      rst_n = 1'b0; start = 1'b0; mode = 2'b00; count = 4'd0;
      din = 4'd0; abort = 1'b0; sin = 1'b0;
      tick(); tick();
      chk("rst_dout", int'(dout), 'h0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      rst_n = 1'b1;
      tick();

      // reset asserted mid-RUN
      start_op(4'b1111, 2'b01, 4'd3);
      chk("mr_busy_load", int'(busy), 1);
      tick();
      chk("mr_step1", int'(dout), 'he);
      rst_n = 1'b0;
      #1;
      chk("mr_dout", int'(dout), 'h0);
      chk("mr_busy", int'(busy), 0);
      chk("mr_done", int'(done), 0);
      tick();
      rst_n = 1'b1;
      tick(); tick(); tick();
      chk("mr_idle_busy", int'(busy), 0);
      chk("mr_idle_done", int'(done), 0);

      // shift left 1001 x1
      start_op(4'b1001, 2'b01, 4'd1);
      chk("sl_load", int'(dout), 'h9);
      chk("sl_busy", int'(busy), 1);
      tick();
      chk("sl_dout", int'(dout), 'h2);
      chk("sl_done", int'(done), 1);
      chk("sl_busy_done", int'(busy), 0);
      tick();
      chk("sl_done_low", int'(done), 0);

      // shift right 1111 x2
      start_op(4'b1111, 2'b10, 4'd2);
      tick();
      chk("sr_step1", int'(dout), 'h7);
      chk("sr_step1_done", int'(done), 0);
      tick();
      chk("sr_dout", int'(dout), 'h3);
      chk("sr_done", int'(done), 1);
      tick();

      // rotate right 1001 x1
      start_op(4'b1001, 2'b11, 4'd1);
      tick();
      chk("rr1_dout", int'(dout), 'hc);
      chk("rr1_done", int'(done), 1);
      tick();

      // rotate right 1011 x4 returns to start value
      start_op(4'b1011, 2'b11, 4'd4);
      wait_done(cyc, nb);
      chk("rr4_done", int'(done), 1);
      chk("rr4_latency", cyc, 4);
      chk("rr4_busy_cycles", nb, 4);
      chk("rr4_dout", int'(dout), 'hb);
      tick();

      // hold x3 acts as delay
      start_op(4'b1011, 2'b00, 4'd3);
      tick();
      chk("hold_mid", int'(dout), 'hb);
      tick(); tick();
      chk("hold_dout", int'(dout), 'hb);
      chk("hold_done", int'(done), 1);
      tick();

      // zero count goes straight to DONE
      start_op(4'b0110, 2'b01, 4'd0);
      chk("z_dout", int'(dout), 'h6);
      chk("z_done", int'(done), 1);
      chk("z_busy", int'(busy), 0);
      tick();
      chk("z_done_low", int'(done), 0);
      chk("z_busy_after", int'(busy), 0);

      // abort after 2 steps, with an ignored start during RUN
      start_op(4'b1111, 2'b10, 4'd4);
      tick();
      chk("ab_step1", int'(dout), 'h7);
      din = 4'b0000; mode = 2'b01; count = 4'd1; start = 1'b1;
      tick();
      start = 1'b0;
      chk("ab_step2", int'(dout), 'h3);
      chk("ab_busy", int'(busy), 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("ab_dout", int'(dout), 'h3);
      chk("ab_done", int'(done), 0);
      chk("ab_busy_low", int'(busy), 0);
      tick();
      chk("ab_no_done", int'(done), 0);
      chk("ab_hold", int'(dout), 'h3);

      // start held through DONE: next accept is one IDLE cycle later
      start_op(4'b0101, 2'b11, 4'd1);
      start = 1'b1; din = 4'b0011; mode = 2'b00; count = 4'd0;
      tick();
      chk("bb_dout", int'(dout), 'ha);
      chk("bb_done", int'(done), 1);
      tick();
      chk("bb_ign_dout", int'(dout), 'ha);
      chk("bb_ign_done", int'(done), 0);
      tick();
      start = 1'b0;
      chk("bb_next_dout", int'(dout), 'h3);
      chk("bb_next_done", int'(done), 1);
      tick();

`ifdef SHIFT_SEQ_SERIAL_IN_EN
      sin = 1'b1;
      start_op(4'b0000, 2'b01, 4'd4);
      wait_done(cyc, nb);
      chk("si_sl_dout", int'(dout), 'hf);
      tick();
      sin = 1'b0;
      start_op(4'b1111, 2'b10, 4'd2);
      wait_done(cyc, nb);
      chk("si_sr_dout", int'(dout), 'h3);
      tick();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
